qs_out_chk: RTL

QS_OUT_CHK -- requirements
Module: qs_out_chk

---
 rtl/qs_out_chk.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/qs_out_chk.sv
// Sorter output checker: snoops sorter input packets into a descriptor FIFO and grades each output packet.
// Optional checksum comparison is compiled in with `define QS_OUT_CHK_CKSUM_EN.
module qs_out_chk #(
   parameter int W      = 32,
   parameter int LEN_W  = 16,
   parameter int DESC_N = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic             in_sop,
   input  logic             in_eop,
   input  logic [W-1:0]     in_dat,
   input  logic             in_rdy_r,
   input  logic             out_vld_r,
   input  logic             out_sop_r,
   input  logic             out_eop_r,
   input  logic             out_err_r,
   input  logic [W-1:0]     out_dat_r,
   output logic             chk_vld_r,
   output logic             chk_pass_r,
   output logic [4:0]       chk_err_r,
   output logic [LEN_W-1:0] pkt_cnt_r,
   output logic [LEN_W-1:0] fail_cnt_r,
   output logic             ovf_r
);

   localparam int AW = (DESC_N > 1) ? $clog2(DESC_N) : 1;
   localparam int CW = $clog2(DESC_N + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   typedef enum logic {IN_IDLE, IN_BODY} in_st_e;
   typedef enum logic {OUT_IDLE, OUT_BODY} out_st_e;

   function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
      return (v == LEN_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DESC_N - 1)) ? '0 : p + 1'b1;
   endfunction

   in_st_e           in_st_q, in_st_d;
   logic [LEN_W-1:0] in_len_q, in_len_d;
   logic             in_hs, push;

   logic [LEN_W-1:0] fifo_len_q [DESC_N];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    fcnt_q, fcnt_d;
   logic             fifo_full, fifo_empty, wr_en, pop, ovf_d;
   logic [LEN_W-1:0] head_len;

   out_st_e          out_st_q, out_st_d;
   logic [LEN_W-1:0] cnt_q, cnt_d, c_cnt;
   logic [W-1:0]     prev_q, prev_d;
   logic             order_q, order_d, proto_q, proto_d, c_ord, c_proto;
   logic             cks_err, abort_v, done_v;
   logic [4:0]       abort_err, done_err;

   logic             v1_vld, v2_vld, iss_vld, pend_vld_q, pend_vld_d;
   logic [4:0]       v1_err, iss_err, pend_err_q, pend_err_d;

   assign in_hs      = in_vld & in_rdy_r;
   assign fifo_full  = (fcnt_q == CW'(DESC_N));
   assign fifo_empty = (fcnt_q == '0);
   assign head_len   = fifo_len_q[rd_ptr_q];

   always_comb begin
      in_st_d  = in_st_q;
      in_len_d = in_len_q;
      push     = 1'b0;
      if (in_hs && in_sop) begin
         in_len_d = LEN_W'(1);
      end else if (in_hs && in_st_q == IN_BODY) begin
         in_len_d = sat_inc(in_len_q);
      end
      if (in_hs && (in_sop || in_st_q == IN_BODY)) begin
         if (in_eop) begin
            push    = 1'b1;
            in_st_d = IN_IDLE;
         end else begin
            in_st_d = IN_BODY;
         end
      end
   end

   // A push into a full FIFO still lands when the same cycle pops the head.
   assign wr_en  = push & (~fifo_full | pop);
   assign ovf_d  = ovf_r | (push & fifo_full & ~pop);
   assign fcnt_d = fcnt_q + CW'(wr_en) - CW'(pop);

   always_comb begin
      out_st_d  = out_st_q;
      cnt_d     = cnt_q;
      prev_d    = prev_q;
      order_d   = order_q;
      proto_d   = proto_q;
      c_cnt     = cnt_q;
      c_ord     = order_q;
      c_proto   = proto_q;
      abort_v   = 1'b0;
      abort_err = '0;
      done_v    = 1'b0;
      done_err  = '0;
      pop       = 1'b0;
      if (out_vld_r) begin
         if (out_sop_r) begin
            c_cnt   = LEN_W'(1);
            c_ord   = 1'b0;
            c_proto = (out_st_q == OUT_IDLE) ? proto_q : 1'b0;
            if (out_st_q == OUT_BODY) begin
               abort_v   = 1'b1;
               abort_err = {2'b00, 1'b1, (cnt_q == LEN_MAX), order_q};
            end
         end else begin
            c_cnt   = sat_inc(cnt_q);
            c_ord   = order_q | (out_dat_r < prev_q);
            c_proto = proto_q;
         end
         if (out_sop_r || out_st_q == OUT_BODY) begin
            if (out_eop_r) begin
               done_v   = 1'b1;
               pop      = ~fifo_empty;
               done_err = {cks_err, out_err_r, c_proto | fifo_empty,
                           (~fifo_empty & (c_cnt != head_len)) | (c_cnt == LEN_MAX), c_ord};
               out_st_d = OUT_IDLE;
               proto_d  = 1'b0;
               order_d  = 1'b0;
            end else begin
               out_st_d = OUT_BODY;
               cnt_d    = c_cnt;
               prev_d   = out_dat_r;
               order_d  = c_ord;
               proto_d  = c_proto;
            end
         end else begin
            proto_d = 1'b1;
         end
      end
   end

`ifdef QS_OUT_CHK_CKSUM_EN
   logic [W-1:0] fifo_sum_q [DESC_N];
   logic [W-1:0] in_sum_q, in_sum_d, osum_q, osum_d, c_osum;

   always_comb begin
      in_sum_d = in_sum_q;
      if (in_hs && in_sop) begin
         in_sum_d = in_dat;
      end else if (in_hs && in_st_q == IN_BODY) begin
         in_sum_d = in_sum_q + in_dat;
      end
      c_osum  = out_sop_r ? out_dat_r : osum_q + out_dat_r;
      osum_d  = (out_vld_r && !out_eop_r && (out_sop_r || out_st_q == OUT_BODY)) ? c_osum : osum_q;
      cks_err = ~fifo_empty & (c_osum != fifo_sum_q[rd_ptr_q]);
   end

   always_ff @(posedge clk) begin
      in_sum_q <= in_sum_d;
      osum_q   <= osum_d;
      if (wr_en) fifo_sum_q[wr_ptr_q] <= in_sum_d;
   end
`else
   logic unused_in_dat;
   assign unused_in_dat = ^in_dat;
   assign cks_err       = 1'b0;
`endif

   // An aborting sop that also ends a packet yields two verdicts; the second waits one cycle in the pend slot.
   assign v1_vld     = abort_v | done_v;
   assign v1_err     = abort_v ? abort_err : done_err;
   assign v2_vld     = abort_v & done_v;
   assign iss_vld    = pend_vld_q | v1_vld;
   assign iss_err    = pend_vld_q ? pend_err_q : v1_err;
   assign pend_vld_d = pend_vld_q ? v1_vld : v2_vld;
   assign pend_err_d = pend_vld_q ? v1_err : done_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_st_q    <= IN_IDLE;
         out_st_q   <= OUT_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fcnt_q     <= '0;
         ovf_r      <= 1'b0;
         proto_q    <= 1'b0;
         order_q    <= 1'b0;
         pend_vld_q <= 1'b0;
         chk_vld_r  <= 1'b0;
         chk_pass_r <= 1'b0;
         chk_err_r  <= '0;
         pkt_cnt_r  <= '0;
         fail_cnt_r <= '0;
      end else begin
         in_st_q    <= in_st_d;
         out_st_q   <= out_st_d;
         if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
         fcnt_q     <= fcnt_d;
         ovf_r      <= ovf_d;
         proto_q    <= proto_d;
         order_q    <= order_d;
         pend_vld_q <= pend_vld_d;
         chk_vld_r  <= iss_vld;
         if (iss_vld) begin
            chk_err_r  <= iss_err;
            chk_pass_r <= (iss_err == '0);
            pkt_cnt_r  <= sat_inc(pkt_cnt_r);
            if (iss_err != '0) fail_cnt_r <= sat_inc(fail_cnt_r);
         end
      end
   end

   always_ff @(posedge clk) begin
      in_len_q   <= in_len_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      pend_err_q <= pend_err_d;
      if (wr_en) fifo_len_q[wr_ptr_q] <= in_len_d;
   end

endmodule
